bc_mem_arbiter: RTL and testbench
=================================

Name: bc_mem_arbiter

Overview:
- Shares one memory port between the instruction-fetch requester (imem) and the load/store requester (dmem) of the core.
- Sits between the core's two memory request channels and the single external memory.
- Allows one outstanding transaction at a time, latches the winning request, and routes the response back to its owner.
- Flags memory-side protocol errors.

Parameters:
- DATA_WIDTH, 32, width of data and the write-data bus.
- ADDR_WIDTH, 32, width of the address bus.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset.
- i_imem_req  in  1  imem request.
- i_imem_addr  in  ADDR_WIDTH  imem address (read only).
- o_imem_gnt  out  1  imem request accepted (pulse).
- o_imem_rvalid  out  1  imem response valid.
- o_imem_rdata  out  DATA_WIDTH  imem read data.
- i_dmem_req  in  1  dmem request.
- i_dmem_we  in  1  dmem write enable.
- i_dmem_addr  in  ADDR_WIDTH  dmem address.
- i_dmem_wdata  in  DATA_WIDTH  dmem write data.
- i_dmem_be  in  DATA_WIDTH/8  dmem byte enables.
- o_dmem_gnt  out  1  dmem request accepted (pulse).
- o_dmem_rvalid  out  1  dmem response valid (reads and writes).
- o_dmem_rdata  out  DATA_WIDTH  dmem read data.
- o_mem_req  out  1  memory request.
- o_mem_we, o_mem_addr, o_mem_wdata, o_mem_be  out  1/ADDR_WIDTH/DATA_WIDTH/DATA_WIDTH/8  latched payload.
- i_mem_gnt  in  1  memory accepted the request.
- i_mem_rvalid  in  1  memory response.
- i_mem_rdata  in  DATA_WIDTH  memory read data.
- o_err  out  1  sticky protocol-error flag.

Behaviour:
- Clocking and reset: one clock (i_clk); reset is asynchronous and active-high (i_rst).
- Reset values: state IDLE; all o_* = 0; owner = DMEM; round-robin pointer = IMEM.
- FSM states are IDLE, REQ and RSP.
- IDLE:
  - If any request is high, pick a winner and register its payload. Imem payload forces we=0 and be=all-ones.
  - Record the owner and go to REQ on the next edge.
  - With no request, stay in IDLE.
- REQ:
  - o_mem_req = 1; payload is held stable from the registers.
  - On i_mem_gnt: o_<owner>_gnt = 1 in the same cycle (combinational), then go to RSP.
- RSP:
  - o_mem_req = 0.
  - On i_mem_rvalid: o_<owner>_rvalid = 1 and o_<owner>_rdata = i_mem_rdata in the same cycle (combinational), then go to IDLE.
  - The non-owner's rvalid stays 0 and its rdata is 0.
- Arbitration: fixed priority, dmem over imem.
- Latency: minimum 3 cycles per transaction (IDLE→REQ→RSP with gnt and rvalid each arriving on the first possible cycle). Back-to-back transactions restart from IDLE.
- Requester rule: a requester holds req and payload until its gnt pulse.
  - If it drops req while in REQ, the latched transaction still completes and its rvalid is still delivered.
- Simultaneous i_mem_gnt and i_mem_rvalid in REQ: gnt is honoured; rvalid is treated as a protocol error.
- i_mem_rvalid while in IDLE or REQ: ignored for routing, and o_err is set.
  - o_err is sticky and is cleared only by reset.
- Reset mid-transaction: asynchronous return to IDLE; o_mem_req drops immediately; the in-flight response is lost and is not flagged.
- Owner bookkeeping:
  - The owner register updates only on IDLE→REQ.
  - The round-robin pointer updates only on gnt.

Optional Feature:
- Macro: BC_ARB_ROUND_ROBIN_EN.
- Defined: when both requesters are high in IDLE, the winner is the requester that was not granted last. The last-granted pointer updates on each gnt; the reset pointer favours dmem first.
- Undefined: fixed dmem-over-imem priority; the pointer logic is absent.

Decomposition:
- Package bc_arb_pkg holds:
  - enum arb_state_e {ST_IDLE, ST_REQ, ST_RSP};
  - enum arb_owner_e {OWN_IMEM, OWN_DMEM};
  - struct mem_req_t {we, addr, wdata, be}, parameterised through localparams matching the defaults.
- One combinational sub-module, bc_arb_picker:
  - inputs: two req bits plus the last-owner pointer;
  - output: the winner;
  - contains the BC_ARB_ROUND_ROBIN_EN logic.

Test Plan:
- Single imem read: imem req, addr=0x100; memory gnt at cycle 2, rvalid at cycle 3 with rdata=0xDEADBEEF.
  - Expect o_mem_addr=0x100, we=0, be=0xF; o_imem_gnt at cycle 2; o_imem_rvalid with 0xDEADBEEF at cycle 3; dmem outputs stay 0.
- Dmem write: addr=0x200, wdata=0x12345678, be=0x3, we=1; memory gnt after 3 stall cycles.
  - Expect the payload held stable for all 4 REQ cycles; o_dmem_rvalid on the memory's ack.
- Contention: both requesters high continuously for 4 transactions.
  - Fixed priority: grants D,D,D,D.
  - With BC_ARB_ROUND_ROBIN_EN: grants D,I,D,I.
- Protocol error: pulse i_mem_rvalid in IDLE.
  - Expect o_err=1, no requester rvalid, and o_err still 1 after 10 further clean transactions.
- Requester drop: dmem deasserts req in REQ before gnt.
  - Expect the transaction to complete and o_dmem_rvalid to pulse once.
- Reset mid-RSP: assert i_rst between gnt and rvalid.
  - Expect o_mem_req=0 and the state IDLE asynchronously; a post-reset imem read completes normally.

Source files
------------

// File: rtl/bc_mem_arbiter_pkg.sv
// Shared types for the imem/dmem memory-port arbiter: FSM states, owner
// encoding and the latched memory request payload.
package bc_arb_pkg;

  localparam int ARB_DATA_WIDTH = 32;
  localparam int ARB_ADDR_WIDTH = 32;
  localparam int ARB_BE_WIDTH   = ARB_DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_RSP
  } arb_state_e;

  typedef enum logic {
    OWN_IMEM,
    OWN_DMEM
  } arb_owner_e;

  typedef struct packed {
    logic                      we;
    logic [ARB_ADDR_WIDTH-1:0] addr;
    logic [ARB_DATA_WIDTH-1:0] wdata;
    logic [ARB_BE_WIDTH-1:0]   be;
  } mem_req_t;

  // Instruction fetches are always full-word reads.
  function automatic mem_req_t imem_payload(input logic [ARB_ADDR_WIDTH-1:0] addr);
    mem_req_t p;
    p.we    = 1'b0;
    p.addr  = addr;
    p.wdata = '0;
    p.be    = '1;
    return p;
  endfunction

endpackage

// File: rtl/bc_mem_arbiter_if.sv
// Bus bundle for the arbiter: imem channel, dmem channel, memory port and
// the error flag. The slave modport is the arbiter's view, master is the
// view of whatever drives the core and memory sides.
interface bc_mem_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;

  logic                  i_imem_req;
  logic [ADDR_WIDTH-1:0] i_imem_addr;
  logic                  o_imem_gnt;
  logic                  o_imem_rvalid;
  logic [DATA_WIDTH-1:0] o_imem_rdata;

  logic                  i_dmem_req;
  logic                  i_dmem_we;
  logic [ADDR_WIDTH-1:0] i_dmem_addr;
  logic [DATA_WIDTH-1:0] i_dmem_wdata;
  logic [BE_WIDTH-1:0]   i_dmem_be;
  logic                  o_dmem_gnt;
  logic                  o_dmem_rvalid;
  logic [DATA_WIDTH-1:0] o_dmem_rdata;

  logic                  o_mem_req;
  logic                  o_mem_we;
  logic [ADDR_WIDTH-1:0] o_mem_addr;
  logic [DATA_WIDTH-1:0] o_mem_wdata;
  logic [BE_WIDTH-1:0]   o_mem_be;
  logic                  i_mem_gnt;
  logic                  i_mem_rvalid;
  logic [DATA_WIDTH-1:0] i_mem_rdata;

  logic                  o_err;

  modport slave (
    input  i_imem_req, i_imem_addr,
    output o_imem_gnt, o_imem_rvalid, o_imem_rdata,
    input  i_dmem_req, i_dmem_we, i_dmem_addr, i_dmem_wdata, i_dmem_be,
    output o_dmem_gnt, o_dmem_rvalid, o_dmem_rdata,
    output o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_be,
    input  i_mem_gnt, i_mem_rvalid, i_mem_rdata,
    output o_err
  );

  modport master (
    output i_imem_req, i_imem_addr,
    input  o_imem_gnt, o_imem_rvalid, o_imem_rdata,
    output i_dmem_req, i_dmem_we, i_dmem_addr, i_dmem_wdata, i_dmem_be,
    input  o_dmem_gnt, o_dmem_rvalid, o_dmem_rdata,
    input  o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_be,
    output i_mem_gnt, i_mem_rvalid, i_mem_rdata,
    input  o_err
  );

endinterface

// File: rtl/bc_mem_arbiter_picker.sv
// Winner selection between the imem and dmem requesters.
// Optional macro BC_ARB_ROUND_ROBIN_EN: on contention, pick the requester
// that was not granted last; otherwise dmem always beats imem.
module bc_arb_picker
  import bc_arb_pkg::*;
(
  input  logic       imem_req,
  input  logic       dmem_req,
  input  arb_owner_e last_owner,
  output arb_owner_e winner
);

`ifdef BC_ARB_ROUND_ROBIN_EN
  // On contention alternate away from the last-granted requester
  always_comb begin
    winner = OWN_DMEM;
    if (imem_req && dmem_req) begin
      winner = (last_owner == OWN_DMEM) ? OWN_IMEM : OWN_DMEM;
    end else if (imem_req) begin
      winner = OWN_IMEM;
    end
  end
`else
  // The pointer is not consulted in fixed-priority builds.
  logic unused_last_owner;
  assign unused_last_owner = last_owner;

  // Fixed priority: dmem wins whenever it is requesting
  always_comb begin
    winner = OWN_DMEM;
    if (!dmem_req && imem_req) begin
      winner = OWN_IMEM;
    end
  end
`endif

endmodule

// File: rtl/bc_mem_arbiter.sv
// Shares one memory port between the imem and dmem requesters with a single
// outstanding transaction, routes the response to its owner and flags
// unexpected memory responses in a sticky error bit.
// Optional macro BC_ARB_ROUND_ROBIN_EN enables round-robin on contention.
module bc_mem_arbiter
  import bc_arb_pkg::*;
#(
  parameter int DATA_WIDTH = ARB_DATA_WIDTH,
  parameter int ADDR_WIDTH = ARB_ADDR_WIDTH
) (
  input logic             i_clk,
  input logic             i_rst,
  bc_mem_arbiter_if.slave bus
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;

  arb_state_e state_reg, state_next;
  arb_owner_e owner_reg;
  arb_owner_e last_owner;
  arb_owner_e winner;
  mem_req_t   payload_reg, payload_next;
  logic       err_reg;
  logic       err_set;
  logic       any_req;
  logic       mem_gnt_taken;

  assign any_req       = bus.i_imem_req | bus.i_dmem_req;
  assign mem_gnt_taken = (state_reg == ST_REQ) && bus.i_mem_gnt;

  bc_arb_picker u_picker (
    .imem_req   (bus.i_imem_req),
    .dmem_req   (bus.i_dmem_req),
    .last_owner (last_owner),
    .winner     (winner)
  );

`ifdef BC_ARB_ROUND_ROBIN_EN
  arb_owner_e last_reg;

  // Remember which requester received the most recent grant
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      last_reg <= OWN_IMEM;
    end else if (mem_gnt_taken) begin
      last_reg <= owner_reg;
    end
  end

  assign last_owner = last_reg;
`else
  assign last_owner = OWN_IMEM;
`endif

  // Build the payload of the current winner; imem is forced to a full read
  always_comb begin
    payload_next = imem_payload(ADDR_WIDTH'(bus.i_imem_addr));
    if (winner == OWN_DMEM) begin
      payload_next.we    = bus.i_dmem_we;
      payload_next.addr  = ADDR_WIDTH'(bus.i_dmem_addr);
      payload_next.wdata = DATA_WIDTH'(bus.i_dmem_wdata);
      payload_next.be    = BE_WIDTH'(bus.i_dmem_be);
    end
  end

  // State, owner, latched payload and sticky error registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg   <= ST_IDLE;
      owner_reg   <= OWN_DMEM;
      payload_reg <= '0;
      err_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      err_reg   <= err_reg | err_set;
      if (state_reg == ST_IDLE && any_req) begin
        owner_reg   <= winner;
        payload_reg <= payload_next;
      end
    end
  end

  // Next-state decode plus combinational grant/response routing
  always_comb begin
    state_next        = state_reg;
    err_set           = 1'b0;
    bus.o_mem_req     = 1'b0;
    bus.o_imem_gnt    = 1'b0;
    bus.o_dmem_gnt    = 1'b0;
    bus.o_imem_rvalid = 1'b0;
    bus.o_dmem_rvalid = 1'b0;
    bus.o_imem_rdata  = '0;
    bus.o_dmem_rdata  = '0;
    case (state_reg)
      ST_IDLE: begin
        // A response with nothing outstanding is a memory-side error
        err_set = bus.i_mem_rvalid;
        if (any_req) begin
          state_next = ST_REQ;
        end
      end
      ST_REQ: begin
        bus.o_mem_req = 1'b1;
        // A response before the grant cannot belong to this request
        err_set = bus.i_mem_rvalid;
        if (bus.i_mem_gnt) begin
          bus.o_imem_gnt = (owner_reg == OWN_IMEM);
          bus.o_dmem_gnt = (owner_reg == OWN_DMEM);
          state_next     = ST_RSP;
        end
      end
      ST_RSP: begin
        if (bus.i_mem_rvalid) begin
          if (owner_reg == OWN_IMEM) begin
            bus.o_imem_rvalid = 1'b1;
            bus.o_imem_rdata  = bus.i_mem_rdata;
          end else begin
            bus.o_dmem_rvalid = 1'b1;
            bus.o_dmem_rdata  = bus.i_mem_rdata;
          end
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign bus.o_mem_we    = payload_reg.we;
  assign bus.o_mem_addr  = payload_reg.addr;
  assign bus.o_mem_wdata = payload_reg.wdata;
  assign bus.o_mem_be    = payload_reg.be;
  assign bus.o_err       = err_reg;

endmodule

// File: tb/tb_bc_mem_arbiter.sv
// Directed self-checking bench for bc_mem_arbiter. Inputs change 1 ns after
// the rising edge, outputs are sampled 1 ns later, well before the next edge.
module tb_bc_mem_arbiter;

  logic clk;
  logic rst;
  int   total_cnt;
  int   pass_cnt;
  int   fail_cnt;
  logic [1:0] exp_win [0:3];

  bc_mem_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus_if ();

  bc_mem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    total_cnt = 0;
    pass_cnt  = 0;
    fail_cnt  = 0;
`ifdef BC_ARB_ROUND_ROBIN_EN
    exp_win[0] = 2'b01; exp_win[1] = 2'b10; exp_win[2] = 2'b01; exp_win[3] = 2'b10;
`else
    exp_win[0] = 2'b01; exp_win[1] = 2'b01; exp_win[2] = 2'b01; exp_win[3] = 2'b01;
`endif

    rst                 = 1'b1;
    bus_if.i_imem_req   = 1'b0;
    bus_if.i_imem_addr  = '0;
    bus_if.i_dmem_req   = 1'b0;
    bus_if.i_dmem_we    = 1'b0;
    bus_if.i_dmem_addr  = '0;
    bus_if.i_dmem_wdata = '0;
    bus_if.i_dmem_be    = '0;
    bus_if.i_mem_gnt    = 1'b0;
    bus_if.i_mem_rvalid = 1'b0;
    bus_if.i_mem_rdata  = '0;

    // Reset state, before any clock edge
    #1;
    chk("rst_mem_req", bus_if.o_mem_req, 0);
    chk("rst_payload", {bus_if.o_mem_we, bus_if.o_mem_be, bus_if.o_mem_addr, bus_if.o_mem_wdata}, 0);
    chk("rst_gnt_rvalid", {bus_if.o_imem_gnt, bus_if.o_dmem_gnt, bus_if.o_imem_rvalid, bus_if.o_dmem_rvalid}, 0);
    chk("rst_err", bus_if.o_err, 0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Single imem read
    bus_if.i_imem_req  = 1'b1;
    bus_if.i_imem_addr = 32'h100;
    settle();
    chk("rd_idle_mem_req", bus_if.o_mem_req, 0);
    tick();
    chk("rd_req_payload", {bus_if.o_mem_req, bus_if.o_mem_we, bus_if.o_mem_be, bus_if.o_mem_addr},
        {1'b1, 1'b0, 4'hF, 32'h100});
    bus_if.i_mem_gnt = 1'b1;
    settle();
    chk("rd_gnt", {bus_if.o_imem_gnt, bus_if.o_dmem_gnt}, 2'b10);
    tick();
    bus_if.i_mem_gnt    = 1'b0;
    bus_if.i_imem_req   = 1'b0;
    bus_if.i_mem_rvalid = 1'b1;
    bus_if.i_mem_rdata  = 32'hDEADBEEF;
    settle();
    chk("rd_rsp_mem_req", bus_if.o_mem_req, 0);
    chk("rd_imem_rsp", {bus_if.o_imem_rvalid, bus_if.o_imem_rdata}, {1'b1, 32'hDEADBEEF});
    chk("rd_dmem_quiet", {bus_if.o_dmem_gnt, bus_if.o_dmem_rvalid, bus_if.o_dmem_rdata}, 0);
    tick();
    bus_if.i_mem_rvalid = 1'b0;
    bus_if.i_mem_rdata  = '0;
    settle();
    chk("rd_done", {bus_if.o_imem_rvalid, bus_if.o_err}, 0);

    // Contention: both requesters held high for four transactions
    bus_if.i_imem_req  = 1'b1;
    bus_if.i_imem_addr = 32'h400;
    bus_if.i_dmem_req  = 1'b1;
    bus_if.i_dmem_we   = 1'b0;
    bus_if.i_dmem_addr = 32'h300;
    bus_if.i_dmem_be   = 4'hF;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("cont_addr", bus_if.o_mem_addr, (exp_win[k] == 2'b01) ? 32'h300 : 32'h400);
      bus_if.i_mem_gnt = 1'b1;
      settle();
      chk("cont_gnt", {bus_if.o_imem_gnt, bus_if.o_dmem_gnt}, exp_win[k]);
      tick();
      bus_if.i_mem_gnt    = 1'b0;
      bus_if.i_mem_rvalid = 1'b1;
      bus_if.i_mem_rdata  = 32'(k);
      settle();
      chk("cont_rvalid", {bus_if.o_imem_rvalid, bus_if.o_dmem_rvalid}, exp_win[k]);
      tick();
      bus_if.i_mem_rvalid = 1'b0;
    end
    bus_if.i_imem_req = 1'b0;
    bus_if.i_dmem_req = 1'b0;
    tick();

    // Dmem write with three stall cycles before the memory grant
    bus_if.i_dmem_req   = 1'b1;
    bus_if.i_dmem_we    = 1'b1;
    bus_if.i_dmem_addr  = 32'h200;
    bus_if.i_dmem_wdata = 32'h12345678;
    bus_if.i_dmem_be    = 4'h3;
    tick();
    for (int s = 0; s < 3; s++) begin
      chk("wr_stall_payload",
          {bus_if.o_dmem_gnt, bus_if.o_mem_req, bus_if.o_mem_we, bus_if.o_mem_be, bus_if.o_mem_addr, bus_if.o_mem_wdata},
          {1'b0, 1'b1, 1'b1, 4'h3, 32'h200, 32'h12345678});
      tick();
    end
    bus_if.i_mem_gnt = 1'b1;
    settle();
    chk("wr_gnt_payload",
        {bus_if.o_imem_gnt, bus_if.o_dmem_gnt, bus_if.o_mem_req, bus_if.o_mem_we, bus_if.o_mem_be, bus_if.o_mem_addr, bus_if.o_mem_wdata},
        {1'b0, 1'b1, 1'b1, 1'b1, 4'h3, 32'h200, 32'h12345678});
    tick();
    bus_if.i_mem_gnt    = 1'b0;
    bus_if.i_dmem_req   = 1'b0;
    bus_if.i_mem_rvalid = 1'b1;
    bus_if.i_mem_rdata  = '0;
    settle();
    chk("wr_ack", {bus_if.o_imem_rvalid, bus_if.o_dmem_rvalid}, 2'b01);
    tick();
    bus_if.i_mem_rvalid = 1'b0;

    // Protocol error: stray response while idle
    bus_if.i_mem_rvalid = 1'b1;
    bus_if.i_mem_rdata  = 32'hBAD0BAD0;
    settle();
    chk("err_no_route", {bus_if.o_imem_rvalid, bus_if.o_dmem_rvalid, bus_if.o_mem_req}, 0);
    tick();
    bus_if.i_mem_rvalid = 1'b0;
    settle();
    chk("err_set", bus_if.o_err, 1);
    for (int n = 0; n < 10; n++) begin
      bus_if.i_imem_req  = 1'b1;
      bus_if.i_imem_addr = 32'(n * 4);
      tick();
      bus_if.i_mem_gnt = 1'b1;
      tick();
      bus_if.i_mem_gnt    = 1'b0;
      bus_if.i_imem_req   = 1'b0;
      bus_if.i_mem_rvalid = 1'b1;
      bus_if.i_mem_rdata  = 32'(n + 32'hA0);
      settle();
      chk("err_clean_rsp", {bus_if.o_imem_rvalid, bus_if.o_imem_rdata}, {1'b1, 32'(n + 32'hA0)});
      tick();
      bus_if.i_mem_rvalid = 1'b0;
    end
    settle();
    chk("err_sticky", bus_if.o_err, 1);

    // Requester drops req while the request is pending at memory
    bus_if.i_dmem_req   = 1'b1;
    bus_if.i_dmem_we    = 1'b0;
    bus_if.i_dmem_addr  = 32'h500;
    bus_if.i_dmem_wdata = '0;
    bus_if.i_dmem_be    = 4'hF;
    tick();
    bus_if.i_dmem_req = 1'b0;
    settle();
    chk("drop_req_held", {bus_if.o_mem_req, bus_if.o_mem_addr}, {1'b1, 32'h500});
    tick();
    bus_if.i_mem_gnt = 1'b1;
    settle();
    chk("drop_gnt", {bus_if.o_imem_gnt, bus_if.o_dmem_gnt}, 2'b01);
    tick();
    bus_if.i_mem_gnt    = 1'b0;
    bus_if.i_mem_rvalid = 1'b1;
    bus_if.i_mem_rdata  = 32'hCAFEF00D;
    settle();
    chk("drop_rsp", {bus_if.o_dmem_rvalid, bus_if.o_dmem_rdata}, {1'b1, 32'hCAFEF00D});
    tick();
    bus_if.i_mem_rvalid = 1'b0;
    settle();
    chk("drop_single_pulse", {bus_if.o_dmem_rvalid, bus_if.o_mem_req}, 0);
    tick();
    chk("drop_no_restart", bus_if.o_mem_req, 0);

    // Reset between grant and response
    bus_if.i_imem_req  = 1'b1;
    bus_if.i_imem_addr = 32'h600;
    tick();
    bus_if.i_mem_gnt = 1'b1;
    tick();
    bus_if.i_mem_gnt  = 1'b0;
    bus_if.i_imem_req = 1'b0;
    settle();
    chk("mid_rsp_mem_req", bus_if.o_mem_req, 0);
    rst = 1'b1;
    settle();
    chk("async_rst_clears", {bus_if.o_err, bus_if.o_mem_req, bus_if.o_mem_addr, bus_if.o_mem_be}, 0);
    #2;
    rst = 1'b0;
    tick();
    bus_if.i_imem_req  = 1'b1;
    bus_if.i_imem_addr = 32'h700;
    tick();
    chk("post_rst_req", {bus_if.o_mem_req, bus_if.o_mem_addr}, {1'b1, 32'h700});
    bus_if.i_mem_gnt = 1'b1;
    settle();
    chk("post_rst_gnt", {bus_if.o_imem_gnt, bus_if.o_dmem_gnt}, 2'b10);
    tick();
    bus_if.i_mem_gnt    = 1'b0;
    bus_if.i_imem_req   = 1'b0;
    bus_if.i_mem_rvalid = 1'b1;
    bus_if.i_mem_rdata  = 32'h11112222;
    settle();
    chk("post_rst_rsp", {bus_if.o_imem_rvalid, bus_if.o_imem_rdata, bus_if.o_err}, {1'b1, 32'h11112222, 1'b0});
    tick();
    bus_if.i_mem_rvalid = 1'b0;

    // Grant and response together in REQ: grant honoured, response is an error
    bus_if.i_imem_req  = 1'b1;
    bus_if.i_imem_addr = 32'h800;
    tick();
    bus_if.i_mem_gnt    = 1'b1;
    bus_if.i_mem_rvalid = 1'b1;
    bus_if.i_mem_rdata  = 32'h55555555;
    settle();
    chk("both_gnt_only", {bus_if.o_imem_gnt, bus_if.o_imem_rvalid, bus_if.o_dmem_rvalid}, 3'b100);
    tick();
    bus_if.i_mem_gnt    = 1'b0;
    bus_if.i_mem_rvalid = 1'b0;
    bus_if.i_imem_req   = 1'b0;
    settle();
    chk("both_err", {bus_if.o_err, bus_if.o_imem_rvalid}, 2'b10);
    bus_if.i_mem_rvalid = 1'b1;
    bus_if.i_mem_rdata  = 32'h66666666;
    settle();
    chk("both_late_rsp", {bus_if.o_imem_rvalid, bus_if.o_imem_rdata}, {1'b1, 32'h66666666});
    tick();
    bus_if.i_mem_rvalid = 1'b0;
    tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
